// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequences the select lines of a downstream 4:1 mux and
// captures one bit per channel into a 4-bit word.
// Each channel is held for SETTLE+1 cycles, and y is sampled on the last
// edge of that dwell window.
// Optional feature: define MUX_SCAN_PARITY_EN to add a registered even-parity
// output that updates together with data_out.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       done,
  output logic [3:0] data_out
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       parity
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  state_t     state_q, state_d;
  logic [1:0] chan_q, chan_d;
  logic [3:0] dwell_q, dwell_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] data_q, data_d;
  logic [1:0] sel_q, sel_d;
`ifdef MUX_SCAN_PARITY_EN
  logic       parity_q, parity_d;
`endif

  // Next-state, dwell/channel sequencing and capture of the sampled word
  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    dwell_d  = dwell_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          chan_d  = 2'd0;
          dwell_d = '0;
        end
      end
      SCAN: begin
        if (dwell_q == SETTLE_W) begin
          dwell_d          = '0;
          shadow_d[chan_q] = y;
          if (chan_q == 2'd3) begin
            state_d = DONE;
            // Load the word including the bit being captured on this edge
            data_d  = shadow_d;
          end else begin
            chan_d = chan_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Registered select follows the channel of the upcoming SCAN cycle
    sel_d = (state_d == SCAN) ? chan_d : 2'b00;
`ifdef MUX_SCAN_PARITY_EN
    parity_d = ^data_d;
`endif
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      chan_q   <= '0;
      dwell_q  <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      sel_q    <= '0;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      dwell_q  <= dwell_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign s0       = sel_q[0];
  assign s1       = sel_q[1];
  assign busy     = (state_q == SCAN);
  assign done     = (state_q == DONE);
  assign data_out = data_q;
`ifdef MUX_SCAN_PARITY_EN
  assign parity   = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl: two instances (SETTLE=1 and SETTLE=0), each
// driving a modelled 4:1 mux. Expected words and done times are queued when
// start is driven and are checked when done is observed.
module tb_mux_scan_ctrl;

  typedef struct {
    logic [3:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0, start0 = 1'b0;
  logic [3:0] in1 = '0, in0 = '0;
  logic y1, y0;
  logic s0_1, s1_1, busy1, done1;
  logic s0_0, s1_0, busy0, done0;
  logic [3:0] data1, data0;
`ifdef MUX_SCAN_PARITY_EN
  logic par1, par0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  exp_t q1[$];
  exp_t q0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Modelled downstream muxes
  always_comb y1 = in1[{s1_1, s0_1}];
  always_comb y0 = in0[{s1_0, s0_0}];

  mux_scan_ctrl #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .y(y1),
    .s0(s0_1), .s1(s1_1), .busy(busy1), .done(done1), .data_out(data1)
`ifdef MUX_SCAN_PARITY_EN
    , .parity(par1)
`endif
  );

  mux_scan_ctrl #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .y(y0),
    .s0(s0_0), .s1(s1_0), .busy(busy0), .done(done0), .data_out(data0)
`ifdef MUX_SCAN_PARITY_EN
    , .parity(par0)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: each done pulse pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done1) begin
      if (q1.size() == 0) check("dut1_unexp_done", 1, 0);
      else begin
        e = q1.pop_front();
        check("dut1_done_cyc", cyc, e.cyc);
        check("dut1_data", {28'd0, data1}, {28'd0, e.data});
`ifdef MUX_SCAN_PARITY_EN
        check("dut1_parity", {31'd0, par1}, {31'd0, ^e.data});
`endif
      end
    end
    if (!rst && done0) begin
      if (q0.size() == 0) check("dut0_unexp_done", 1, 0);
      else begin
        e = q0.pop_front();
        check("dut0_done_cyc", cyc, e.cyc);
        check("dut0_data", {28'd0, data0}, {28'd0, e.data});
`ifdef MUX_SCAN_PARITY_EN
        check("dut0_parity", {31'd0, par0}, {31'd0, ^e.data});
`endif
      end
    end
  end

  // One full scan on the instance whose SETTLE equals 'which'; called at a negedge
  task automatic do_scan(input int which, input logic [3:0] inputs);
    int w = which + 1;
    exp_t e;
    e.data = inputs;
    e.cyc  = cyc + 1 + 4 * w;
    if (which == 1) begin in1 = inputs; start1 = 1'b1; q1.push_back(e); end
    else            begin in0 = inputs; start0 = 1'b1; q0.push_back(e); end
    for (int i = 1; i <= 4 * w; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      start0 = 1'b0;
      if (which == 1) begin
        check("dut1_sel", {30'd0, s1_1, s0_1}, 32'((i - 1) / w));
        check("dut1_busy", {31'd0, busy1}, 1);
      end else begin
        check("dut0_sel", {30'd0, s1_0, s0_0}, 32'((i - 1) / w));
        check("dut0_busy", {31'd0, busy0}, 1);
      end
    end
    @(negedge clk);
    if (which == 1) begin
      check("dut1_busy_done", {31'd0, busy1}, 0);
      check("dut1_sel_done", {30'd0, s1_1, s0_1}, 0);
    end else begin
      check("dut0_busy_done", {31'd0, busy0}, 0);
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int c0;
    bit found;
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_busy", {31'd0, busy1}, 0);
    check("rst_done", {31'd0, done1}, 0);
    check("rst_sel", {30'd0, s1_1, s0_1}, 0);
    check("rst_data1", {28'd0, data1}, 0);
    check("rst_data0", {28'd0, data0}, 0);
`ifdef MUX_SCAN_PARITY_EN
    check("rst_parity", {31'd0, par1}, 0);
`endif
    rst = 1'b0;   // start honoured on the first edge after reset release
    do_scan(1, 4'b1001);
    do_scan(0, 4'b1110);

    // Inputs change while idle: data_out must hold
    in1 = 4'b0110;
    repeat (5) begin
      @(negedge clk);
      check("hold_data", {28'd0, data1}, 32'h9);
    end
    do_scan(1, 4'b0110);

    // start held high: scans begin every 10 cycles
    in1 = 4'b0101;
    start1 = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      e.data = 4'b0101;
      e.cyc  = c0 + 1 + 10 * k + 8;
      q1.push_back(e);
    end
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      check("cont_busy", {31'd0, busy1}, {31'd0, ((j - 1) % 10) < 8});
    end
    start1 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-scan while select is 10
    in1 = 4'b1111;
    start1 = 1'b1;
    found = 1'b0;
    for (int j = 0; j < 12 && !found; j++) begin
      @(negedge clk);
      start1 = 1'b0;
      if ({s1_1, s0_1} == 2'b10) found = 1'b1;
    end
    check("sel10_reached", {31'd0, found}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy1}, 0);
    check("abort_data", {28'd0, data1}, 0);
    check("abort_sel", {30'd0, s1_1, s0_1}, 0);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, done1}, 0);
    end

    // rst and start on the same edge: reset wins
    rst = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    check("rst_prio_busy", {31'd0, busy1}, 0);
    start1 = 1'b0;
    @(negedge clk);
    check("rst_prio_busy2", {31'd0, busy1}, 0);
    rst = 1'b0;
    do_scan(1, 4'b0011);

    repeat (12) @(negedge clk);
    check("q1_drained", q1.size(), 0);
    check("q0_drained", q0.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 1: extra dwell cycles per channel before sampling; legal range 0..15.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  scan request; sampled only in IDLE.
REQ-005 y  input  1  output of the downstream 4:1 mux under control.
REQ-006 s0  output  1  mux select LSB; registered.
REQ-007 s1  output  1  mux select MSB; registered.
REQ-008 busy  output  1  high while in SCAN.
REQ-009 done  output  1  single-cycle pulse; data_out is valid and newly updated.
REQ-010 data_out  output  4  captured word; bit k is y sampled while {s1,s0}=k.
REQ-011 parity  output  1  even parity of data_out; present only when MUX_SCAN_PARITY_EN is defined.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-013 IDLE: {s1,s0}=00, busy=0, done=0; start=1 at an edge -> SCAN with channel=0 and dwell=0.
REQ-014 SCAN: {s1,s0} = channel; busy=1; dwell increments 0..SETTLE each cycle.
REQ-015 At the edge where dwell==SETTLE, y SHALL be captured into shadow bit [channel] and dwell reset to 0.
REQ-016 At that same edge, channel increments if below 3; if channel==3 -> DONE and the full shadow word (including this final bit) loads into data_out.
REQ-017 Each channel SHALL occupy exactly SETTLE+1 cycles; SCAN lasts 4*(SETTLE+1) cycles.
REQ-018 Latency: done is high in the cycle following edge 4*(SETTLE+1), counted from the edge that sampled start (edge 0).
REQ-019 DONE: done=1, busy=0, {s1,s0}=00; unconditional transition to IDLE after one cycle.
REQ-020 start SHALL be ignored in SCAN and DONE; no queuing. Back-to-back scans therefore occur at most once every 4*(SETTLE+1)+2 cycles.
REQ-021 data_out SHALL change only at entry to DONE or on reset, and holds its value between scans.
REQ-022 The select value SHALL change only on a dwell-window boundary, never mid-window.
REQ-023 y is assumed stable on the sampling edge; the block adds no synchroniser.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, channel=0, dwell=0, {s1,s0}=00, busy=0, done=0, data_out=0, shadow=0 and parity=0; rst takes priority over start.
REQ-025 Reset mid-SCAN SHALL abandon the scan: done stays low and data_out reads 0.
REQ-026 After rst deasserts, start is honoured on the first edge.

Configuration
REQ-027 With MUX_SCAN_PARITY_EN defined, parity SHALL be the XOR of the four data_out bits, registered together with data_out (same edge).
REQ-028 Without MUX_SCAN_PARITY_EN, the parity port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-029 SETTLE=1, mux inputs I0..I3=1,0,0,1, start pulse -> select sequence 00,00,01,01,10,10,11,11; done pulses at cycle 9 with data_out=4'b1001 (parity=0 when enabled).
REQ-030 SETTLE=0, I0..I3=0,1,1,1 -> each select value held 1 cycle; done at cycle 5; data_out=4'b1110; parity=1 when enabled.
REQ-031 start held high continuously, SETTLE=1 -> scans start at edges 0, 10 and 20; busy is low exactly in the DONE and IDLE cycles between scans.
REQ-032 rst asserted while {s1,s0}=10 -> next cycle IDLE, busy=0, data_out=0; no done pulse appears in the following 20 cycles.
REQ-033 Mux inputs changed during DONE/IDLE after a completed scan -> data_out holds its old value until the next done.
REQ-034 start and rst high on the same edge -> block remains in IDLE, busy=0.
